music_sequencer: RTL and testbench
==================================

# music_sequencer

Parametrised ROM-driven auto-play sequencer for the electric piano: replaces the fixed-tempo, fixed-song player. It selects one of `SONGS` songs, fetches `{duration, tone}` note words from an external synchronous ROM, and emits a tone code per note. Notes have per-note durations in beats and a configurable articulation gap, with pause, loop and end-of-song signalling. `auto_tone` feeds the existing tone-to-PWM buzzer path; mode 0 / `enable` low leaves the path silent for manual play.

## Interface
- `TONE_W`, 16, tone code width (0 = silence)
- `DUR_W`, 3, note duration field width in beats; duration 0 = end-of-song marker
- `SONGS`, 4, number of songs; power of two, ≥2
- `NOTES`, 64, max note slots per song; power of two
- `BEAT_TICKS`, 3_000_000, clk cycles per beat (250 ms at 12 MHz); ≥2
- `GAP_TICKS`, 300_000, silent cycles at the end of every note; 0 ≤ GAP_TICKS < BEAT_TICKS
- `SEL_W`, 3, width of `song_sel`
- `clk` in 1 system clock (12 MHz)
- `rst_n` in 1 asynchronous active-low reset
- `song_sel` in SEL_W: 0 = off/manual; 1..SONGS = song index+1; >SONGS = off
- `enable` in 1 play enable
- `pause` in 1 freeze playback, output silent
- `loop` in 1 restart song at its end instead of stopping
- `rom_addr` out log2(SONGS)+log2(NOTES) registered `{song_idx, note_idx}`
- `rom_data` in DUR_W+TONE_W `{dur, tone}`; valid one cycle after `rom_addr` changes (registered ROM)
- `auto_tone` out TONE_W registered tone code
- `note_index` out log2(NOTES) index of the current note
- `playing` out 1 high in FETCH/LATCH/PLAY/GAP/END
- `song_finished` out 1 one-cycle pulse at end of song

## Operation
- States: IDLE, FETCH, LATCH, PLAY, GAP, END, DONE.
- IDLE: `auto_tone`=0, `note_index`=0. If `enable` && 1≤`song_sel`≤SONGS: latch song_idx=`song_sel`-1, `rom_addr`={song_idx,0} → FETCH.
- FETCH: wait one cycle for ROM → LATCH.
- LATCH: sample `rom_data`.
  - dur==0 → END.
  - Otherwise: load tone; tick counter = dur*BEAT_TICKS−1 → PLAY.
- PLAY: `auto_tone`=tone; decrement counter. When counter reaches GAP_TICKS−1 → GAP (with GAP_TICKS=0, skip GAP and behave as at GAP completion).
- GAP: `auto_tone`=0; decrement. At counter 0:
  - if `note_index`==NOTES−1 → END;
  - else `note_index`+1, `rom_addr` updated → FETCH.
- END: `song_finished`=1 for this cycle only.
  - If `loop`: `note_index`=0, `rom_addr`={song_idx,0} → FETCH.
  - Else → DONE.
- DONE: `auto_tone`=0, `playing`=0. → IDLE when `enable` low or `song_sel`≠latched value.
- Abort: in any state except IDLE/DONE, `enable` low or `song_sel`≠latched value → IDLE at the next edge. Outputs: `auto_tone`=0, `note_index`=0, no `song_finished`. Abort has priority over every other transition and over `pause`.
- `pause` high: state, counter, `note_index` and `rom_addr` hold. `auto_tone`=0 while `pause`=1. On release, resume from the held count; the held tone reappears the cycle after release. `pause` in END still emits the pulse once, then holds in END's successor.
- Arithmetic: tick counter is unsigned, width log2((2^DUR_W−1)*BEAT_TICKS+1). The dur*BEAT_TICKS product uses constant multiply, no truncation. `note_index` does not wrap into the next song.

## Timing
- Reset values: state IDLE; `auto_tone`=0, `rom_addr`=0, `note_index`=0, `playing`=0, `song_finished`=0.
- Start latency: `enable` sampled at edge k → `rom_addr` valid after k → `auto_tone` = first tone after edge k+2.
- Note period: dur*BEAT_TICKS cycles in PLAY+GAP, plus 2 silent fetch cycles (FETCH, LATCH).
  - Tone audible dur*BEAT_TICKS−GAP_TICKS cycles.
  - Silent GAP_TICKS+2 cycles between notes.
- End: END occupies 1 cycle. With `loop`, the first tone returns 3 edges after END is entered.
- All outputs are registered; none depend combinationally on inputs.

## Test plan
- Params BEAT_TICKS=10, GAP_TICKS=2, SONGS=2, NOTES=4; song 1 ROM = {1,262},{2,294},{0,x}; `enable`=1, `song_sel`=1 at edge 0 → `auto_tone`=262 for cycles 3–10, 0 for 11–14, 294 for 15–32, then 0; `song_finished` single pulse; `playing` falls after it.
- Same, `loop`=1 → second 262 begins 3 cycles after the pulse; pulse repeats each pass.
- Song 2 fully populated (4 notes, dur=1, no terminator) → `note_index` 0..3; END after index 3; `rom_addr` never exceeds {1,3}.
- `pause` for 20 cycles mid-PLAY of 294 → `auto_tone`=0 during pause; remaining 294 cycles after release equal the remaining count before pause.
- `song_sel` changed 1→2 mid-note → IDLE next edge, `auto_tone`=0, no pulse; song 2 restarts from note 0.
- `rst_n` asserted asynchronously mid-GAP → all outputs 0 immediately; after release, play does not start until `enable` is sampled high in IDLE.

Source files
------------

// File: rtl/music_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : music_sequencer_if
//  Purpose  : Bundles the auto-play sequencer's control inputs, its ROM fetch
//             bus and its tone / status outputs.
//  Ports    : song_sel, enable, pause, loop  - playback control
//             rom_addr / rom_data            - synchronous song ROM bus
//             auto_tone, note_index, playing, song_finished - player outputs
//  Modports : slave  - the sequencer
//             master - the surrounding system (controls + ROM)
//  Revision : 1.0 - initial release
// ============================================================================
interface music_sequencer_if #(
    parameter int TONE_W = 16,
    parameter int DUR_W  = 3,
    parameter int SEL_W  = 3,
    parameter int SONGS  = 4,
    parameter int NOTES  = 64
) ();
    localparam int c_addr_w = $clog2(SONGS) + $clog2(NOTES);
    localparam int c_ni_w   = $clog2(NOTES);

    logic [SEL_W-1:0]        song_sel;
    logic                    enable;
    logic                    pause;
    logic                    loop;
    logic [c_addr_w-1:0]     rom_addr;
    logic [DUR_W+TONE_W-1:0] rom_data;
    logic [TONE_W-1:0]       auto_tone;
    logic [c_ni_w-1:0]       note_index;
    logic                    playing;
    logic                    song_finished;

    modport slave (
        input  song_sel, enable, pause, loop, rom_data,
        output rom_addr, auto_tone, note_index, playing, song_finished
    );

    modport master (
        output song_sel, enable, pause, loop, rom_data,
        input  rom_addr, auto_tone, note_index, playing, song_finished
    );
endinterface
`default_nettype wire

// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : music_sequencer
//  Purpose  : ROM-driven auto-play sequencer. Walks {duration, tone} words of
//             the selected song, plays each tone for its duration in beats
//             minus an articulation gap, and signals end of song.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - music_sequencer_if.slave (controls, ROM bus, outputs)
//  Revision : 1.0 - initial release
// ============================================================================
module music_sequencer #(
    parameter int TONE_W     = 16,
    parameter int DUR_W      = 3,
    parameter int SONGS      = 4,
    parameter int NOTES      = 64,
    parameter int BEAT_TICKS = 3_000_000,
    parameter int GAP_TICKS  = 300_000,
    parameter int SEL_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    music_sequencer_if.slave bus
);
    localparam int c_si_w  = $clog2(SONGS);
    localparam int c_ni_w  = $clog2(NOTES);
    // Wide enough for the longest note: (2^DUR_W-1) beats.
    localparam int c_cnt_w = $clog2((2**DUR_W - 1) * BEAT_TICKS + 1);

    localparam logic [c_cnt_w-1:0] c_beat = c_cnt_w'(BEAT_TICKS);
    localparam logic [c_cnt_w-1:0] c_gap  = c_cnt_w'(GAP_TICKS);
    localparam logic [c_ni_w-1:0]  c_last = c_ni_w'(NOTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_END   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [c_si_w-1:0]   r_song_idx;
    logic [c_ni_w-1:0]   r_note_idx;
    logic [TONE_W-1:0]   r_tone;
    logic [TONE_W-1:0]   r_auto_tone;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_playing;
    logic                r_finished;

    logic [DUR_W-1:0]    w_rom_dur;
    logic [TONE_W-1:0]   w_rom_tone;
    logic [c_cnt_w-1:0]  w_load;
    logic [c_si_w-1:0]   w_sel_idx;
    logic                w_sel_valid;
    logic                w_abort;
    logic                w_note_done;

    assign w_rom_dur   = bus.rom_data[DUR_W+TONE_W-1 -: DUR_W];
    assign w_rom_tone  = bus.rom_data[TONE_W-1:0];
    assign w_load      = c_cnt_w'(w_rom_dur) * c_beat - c_cnt_w'(1);
    assign w_sel_idx   = c_si_w'(bus.song_sel - SEL_W'(1));
    assign w_sel_valid = (bus.song_sel != '0) && (32'(bus.song_sel) <= 32'(SONGS));

    // Losing enable or changing the selection kills any song in flight.
    assign w_abort = (r_state != S_IDLE) && (r_state != S_DONE) &&
                     (!bus.enable || (bus.song_sel != r_sel));

    // End of the note's tick budget; without a gap PLAY finishes the note itself.
    assign w_note_done = (r_cnt == '0) &&
                         ((r_state == S_GAP) || ((GAP_TICKS == 0) && (r_state == S_PLAY)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_song_idx  <= '0;
            r_note_idx  <= '0;
            r_tone      <= '0;
            r_auto_tone <= '0;
            r_cnt       <= '0;
            r_playing   <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            // Silent and no pulse unless a branch below says otherwise.
            r_auto_tone <= '0;
            r_finished  <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                r_note_idx <= '0;
                r_playing  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_note_idx <= '0;
                        if (bus.enable && w_sel_valid) begin
                            r_sel      <= bus.song_sel;
                            r_song_idx <= w_sel_idx;
                            r_playing  <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (!bus.pause) begin
                            r_state <= S_LATCH;
                        end
                    end
                    S_LATCH: begin
                        if (!bus.pause) begin
                            if (w_rom_dur == '0) begin
                                r_state    <= S_END;
                                r_finished <= 1'b1;
                            end else begin
                                r_tone      <= w_rom_tone;
                                r_auto_tone <= w_rom_tone;
                                r_cnt       <= w_load;
                                r_state     <= S_PLAY;
                            end
                        end
                    end
                    S_PLAY, S_GAP: begin
                        if (!bus.pause) begin
                            if (w_note_done) begin
                                if (r_note_idx == c_last) begin
                                    r_state    <= S_END;
                                    r_finished <= 1'b1;
                                end else begin
                                    r_note_idx <= r_note_idx + 1'b1;
                                    r_state    <= S_FETCH;
                                end
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                                if (r_state == S_PLAY) begin
                                    if (r_cnt == c_gap) begin
                                        r_state <= S_GAP;
                                    end else begin
                                        r_auto_tone <= r_tone;
                                    end
                                end
                            end
                        end
                    end
                    S_END: begin
                        // Leaves regardless of pause so the pulse is one cycle wide.
                        if (bus.loop) begin
                            r_note_idx <= '0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_playing <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (!bus.enable || (bus.song_sel != r_sel)) begin
                            r_note_idx <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rom_addr      = {r_song_idx, r_note_idx};
    assign bus.auto_tone     = r_auto_tone;
    assign bus.note_index    = r_note_idx;
    assign bus.playing       = r_playing;
    assign bus.song_finished = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_music_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_music_sequencer
//  Purpose  : Self-checking bench for music_sequencer. A reference model turns
//             the song ROM contents into the expected per-cycle output trace;
//             pause stretches the trace by repeating the current step silently.
//  Ports    : none (top level)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_music_sequencer;
    localparam int TONE_W = 16;
    localparam int DUR_W  = 3;
    localparam int SEL_W  = 3;
    localparam int SONGS  = 2;
    localparam int NOTES  = 4;
    localparam int BT     = 10;
    localparam int GAP    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    music_sequencer_if #(.TONE_W(TONE_W), .DUR_W(DUR_W), .SEL_W(SEL_W),
                         .SONGS(SONGS), .NOTES(NOTES)) bus ();

    music_sequencer #(
        .TONE_W(TONE_W), .DUR_W(DUR_W), .SONGS(SONGS), .NOTES(NOTES),
        .BEAT_TICKS(BT), .GAP_TICKS(GAP), .SEL_W(SEL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered song ROM.
    int unsigned rom_dur  [SONGS][NOTES];
    int unsigned rom_tone [SONGS][NOTES];
    always @(posedge clk)
        bus.rom_data <= {DUR_W'(rom_dur[bus.rom_addr[2]][bus.rom_addr[1:0]]),
                         TONE_W'(rom_tone[bus.rom_addr[2]][bus.rom_addr[1:0]])};

    typedef struct {
        int tone;
        bit play;
        bit fin;
        int idx;
        int addr;
    } exp_t;

    exp_t q[$];
    exp_t prev;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   watch_tone = -1;
    int   watch_cnt  = 0;

    function automatic void push(int tone, bit play, bit fin, int idx, int s);
        exp_t e;
        e.tone = tone; e.play = play; e.fin = fin; e.idx = idx; e.addr = s * NOTES + idx;
        q.push_back(e);
    endfunction

    // One pass through song s: two silent fetch cycles per note, audible part,
    // gap, and a one-cycle end marker.
    function automatic void build_pass(int s);
        for (int i = 0; i < NOTES; i++) begin
            push(0, 1, 0, i, s);
            push(0, 1, 0, i, s);
            if (rom_dur[s][i] == 0) begin
                push(0, 1, 1, i, s);
                return;
            end
            repeat (rom_dur[s][i] * BT - GAP) push(int'(rom_tone[s][i]), 1, 0, i, s);
            repeat (GAP) push(0, 1, 0, i, s);
        end
        push(0, 1, 1, NOTES - 1, s);
    endfunction

    function automatic void push_done(int n, int s);
        int last;
        last = q[$].idx;
        repeat (n) push(0, 0, 0, last, s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step(input bit p, input string tag);
        exp_t e;
        bus.pause = p;
        @(posedge clk);
        #1;
        if (p && prev.play && !prev.fin) begin
            e = prev;
            e.tone = 0;
        end else if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s.queue: observed 0 expected >0 model steps", tag);
            e = prev;
        end else begin
            e = q.pop_front();
        end
        if (int'(bus.auto_tone) == watch_tone) watch_cnt++;
        chk({tag, ".tone"}, 32'(bus.auto_tone),     32'(e.tone));
        chk({tag, ".play"}, 32'(bus.playing),       32'(e.play));
        chk({tag, ".fin"},  32'(bus.song_finished), 32'(e.fin));
        chk({tag, ".idx"},  32'(bus.note_index),    32'(e.idx));
        if (e.play) chk({tag, ".addr"}, 32'(bus.rom_addr), 32'(e.addr));
        prev = e;
    endtask

    task automatic run_all(input int pause_pct, input string tag);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 3000) begin
            step($urandom_range(0, 99) < pause_pct, tag);
            guard++;
        end
        chk({tag, ".drain"}, 32'(q.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tone"}, 32'(bus.auto_tone),     32'd0);
        chk({tag, ".play"}, 32'(bus.playing),       32'd0);
        chk({tag, ".fin"},  32'(bus.song_finished), 32'd0);
        chk({tag, ".idx"},  32'(bus.note_index),    32'd0);
        chk({tag, ".addr"}, 32'(bus.rom_addr),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.enable = 1'b0; bus.song_sel = '0; bus.pause = 1'b0; bus.loop = 1'b0;

        // Song 1: two notes then terminator; slot 3 unreachable.
        rom_dur[0][0] = 1; rom_tone[0][0] = 262;
        rom_dur[0][1] = 2; rom_tone[0][1] = 294;
        rom_dur[0][2] = 0; rom_tone[0][2] = $urandom_range(1, 65535);
        rom_dur[0][3] = $urandom_range(1, 7); rom_tone[0][3] = $urandom_range(1, 65535);
        // Song 2: every slot used, one beat each, random tones.
        for (int i = 0; i < NOTES; i++) begin
            rom_dur[1][i]  = 1;
            rom_tone[1][i] = $urandom_range(1, 65535);
        end

        // Reset state.
        #1 rst_n = 1'b0;
        #1 chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        prev = '{tone: 0, play: 0, fin: 0, idx: 0, addr: 0};

        // Valid selection but enable low: stays idle.
        bus.song_sel = SEL_W'(1);
        repeat (3) push(0, 0, 0, 0, 0);
        run_all(0, "idle_noenable");

        // Plain play of song 1 to the end.
        bus.enable = 1'b1;
        build_pass(0);
        push_done(4, 0);
        run_all(0, "song1");

        // Leave DONE by dropping enable.
        bus.enable = 1'b0;
        push(0, 0, 0, 0, 0);
        run_all(0, "done_exit");

        // Loop: two full passes and the start of a third, then abort.
        bus.enable = 1'b1;
        bus.loop   = 1'b1;
        build_pass(0);
        build_pass(0);
        k = q.size() + 5;
        build_pass(0);
        for (int i = 0; i < k; i++) step(1'b0, "loop");
        q.delete();
        bus.loop   = 1'b0;
        bus.enable = 1'b0;
        push(0, 0, 0, 0, 0);
        run_all(0, "loop_abort");

        // 20-cycle pause in the middle of the 294 note.
        bus.enable = 1'b1;
        build_pass(0);
        push_done(3, 0);
        watch_tone = 294;
        watch_cnt  = 0;
        k = 14 + $urandom_range(2, 12);
        for (int i = 0; i < k; i++) step(1'b0, "pause_pre");
        for (int i = 0; i < 20; i++) step(1'b1, "pause_hold");
        run_all(0, "pause_post");
        chk("pause_294_len", 32'(watch_cnt), 32'd18);
        watch_tone = -1;

        // Song 2 with random pauses; runs to END after the last slot.
        bus.song_sel = SEL_W'(2);
        push(0, 0, 0, 0, 1);
        build_pass(1);
        push_done(3, 1);
        run_all(25, "song2");

        // Selection change mid-note aborts; song 2 then restarts from note 0.
        bus.song_sel = SEL_W'(1);
        push(0, 0, 0, 0, 0);
        build_pass(0);
        k = 1 + 2 + 3 + $urandom_range(0, 4);
        for (int i = 0; i < k; i++) step(1'b0, "abort_pre");
        bus.song_sel = SEL_W'(2);
        q.delete();
        push(0, 0, 0, 0, 1);
        step(1'b0, "abort");
        build_pass(1);
        push_done(2, 1);
        run_all(0, "abort_song2");

        // Asynchronous reset in the first gap cycle of song 1.
        bus.song_sel = SEL_W'(1);
        push(0, 0, 0, 0, 0);
        build_pass(0);
        for (int i = 0; i < 1 + 2 + 8 + 1; i++) step(1'b0, "rst_pre");
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        bus.enable = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        prev = '{tone: 0, play: 0, fin: 0, idx: 0, addr: 0};
        repeat (3) push(0, 0, 0, 0, 0);
        run_all(0, "rst_idle");
        bus.enable = 1'b1;
        build_pass(0);
        for (int i = 0; i < 6; i++) step(1'b0, "rst_restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
